// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: opcodes, funct3 codes, byte-lane
// masks and the FSM state type.
package ex_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MEM_SEL_B = 4'b0001;
  localparam logic [3:0] MEM_SEL_H = 4'b0011;
  localparam logic [3:0] MEM_SEL_W = 4'b1111;

  typedef enum logic {
    EX_IDLE     = 1'b0,
    EX_MEM_WAIT = 1'b1
  } ex_state_t;

endpackage

// File: rtl/ex_lsu.sv
// Combinational load/store datapath: effective address, lane select, store
// replication, misalign detection and extraction of returned load data.
module ex_lsu
  import ex_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] store_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_rdata,
  output logic [31:0] addr,
  output logic [31:0] word_addr,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    addr      = op1 + op2;
    word_addr = {addr[31:2], 2'b00};
    sel       = MEM_SEL_W;
    wdata     = store_data;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        sel   = MEM_SEL_B << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel      = MEM_SEL_H << addr[1:0];
        wdata    = {2{store_data[15:0]}};
        misalign = addr[0];
      end
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end

  // Load data comes from the registered request, not the current bundle.
  always_comb begin
    case (load_offset)
      2'd0:    load_byte = load_rdata[7:0];
      2'd1:    load_byte = load_rdata[15:8];
      2'd2:    load_byte = load_rdata[23:16];
      default: load_byte = load_rdata[31:24];
    endcase
    load_half = load_offset[1] ? load_rdata[31:16] : load_rdata[15:0];
    case (load_funct3)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LBU:  load_data = {24'd0, load_byte};
      F3_LHU:  load_data = {16'd0, load_half};
      default: load_data = load_rdata;
    endcase
  end

endmodule

// File: rtl/ex.sv
// RV32I execute stage: ALU, CSR, branch/jump resolution and a two-state FSM
// that holds off upstream while a data-bus access is outstanding.
module ex
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] op1_jump_i,
  input  logic [31:0] op2_jump_i,
  input  logic [31:0] reg1_rdata_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_rdata_i,
  input  logic [31:0] csr_waddr_i,
  output logic        ready_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        misalign_o,
  output ex_state_t   fsm_state
);

  // Handshake: a bundle is consumed on a rising edge where valid_i & ready_o
  // & ~jump_flag_o; bundles seen while jump_flag_o is high are wrong-path.
  ex_state_t   state;
  logic        accept;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        rd_write;
  logic [31:0] op_sum;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic [31:0] jump_sum;
  logic [31:0] csr_src;
  logic [31:0] csr_next;

  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [4:0]  ld_rd;
  logic        ld_we;

  logic [31:0] lsu_addr;
  logic [31:0] lsu_word_addr;
  logic [3:0]  lsu_sel;
  logic [31:0] lsu_wdata;
  logic        lsu_misalign;
  logic [31:0] lsu_load_data;

  logic        unused_bits;
  assign unused_bits = ^{inst_i[31], inst_i[29:20], inst_i[11:7], inst_addr_i,
                         lsu_addr[1:0]};

  assign ready_o   = (state == EX_IDLE);
  assign fsm_state = state;
  assign accept    = valid_i & ready_o & ~jump_flag_o;
  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign rd_write  = reg_we_i & (reg_waddr_i != 5'd0);
  assign op_sum    = op1_i + op2_i;
  assign jump_sum  = op1_jump_i + op2_jump_i;

  always_comb begin
    case (funct3)
      3'b000:  alu_result = (opcode == OPC_OP && inst_i[30]) ? op1_i - op2_i : op_sum;
      3'b001:  alu_result = op1_i << op2_i[4:0];
      3'b010:  alu_result = {31'd0, $signed(op1_i) < $signed(op2_i)};
      3'b011:  alu_result = {31'd0, op1_i < op2_i};
      3'b100:  alu_result = op1_i ^ op2_i;
      3'b101:  alu_result = inst_i[30] ? $unsigned($signed(op1_i) >>> op2_i[4:0])
                                       : op1_i >> op2_i[4:0];
      3'b110:  alu_result = op1_i | op2_i;
      default: alu_result = op1_i & op2_i;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = (op1_i == op2_i);
      F3_BNE:  branch_taken = (op1_i != op2_i);
      F3_BLT:  branch_taken = ($signed(op1_i) < $signed(op2_i));
      F3_BGE:  branch_taken = ($signed(op1_i) >= $signed(op2_i));
      F3_BLTU: branch_taken = (op1_i < op2_i);
      F3_BGEU: branch_taken = (op1_i >= op2_i);
      default: branch_taken = 1'b0;
    endcase
  end

  // funct3[2] selects the zimm forms; funct3[1:0] picks RW / RS / RC.
  always_comb begin
    csr_src = funct3[2] ? {27'd0, inst_i[19:15]} : reg1_rdata_i;
    case (funct3[1:0])
      2'b01:   csr_next = csr_src;
      2'b10:   csr_next = csr_rdata_i | csr_src;
      2'b11:   csr_next = csr_rdata_i & ~csr_src;
      default: csr_next = csr_rdata_i;
    endcase
  end

  ex_lsu u_lsu (
    .funct3      (funct3),
    .op1         (op1_i),
    .op2         (op2_i),
    .store_data  (reg2_rdata_i),
    .load_funct3 (ld_funct3),
    .load_offset (ld_offset),
    .load_rdata  (mem_rdata_i),
    .addr        (lsu_addr),
    .word_addr   (lsu_word_addr),
    .sel         (lsu_sel),
    .wdata       (lsu_wdata),
    .misalign    (lsu_misalign),
    .load_data   (lsu_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EX_IDLE;
      jump_flag_o <= 1'b0;
      jump_addr_o <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_sel_o   <= '0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      misalign_o  <= 1'b0;
      ld_funct3   <= '0;
      ld_offset   <= '0;
      ld_rd       <= '0;
      ld_we       <= 1'b0;
    end else begin
      reg_we_o    <= 1'b0;
      csr_we_o    <= 1'b0;
      jump_flag_o <= 1'b0;
      misalign_o  <= 1'b0;
      case (state)
        EX_IDLE: begin
          if (accept) begin
            case (opcode)
              OPC_LUI, OPC_AUIPC: begin
                reg_we_o    <= rd_write;
                reg_waddr_o <= reg_waddr_i;
                reg_wdata_o <= op_sum;
              end
              OPC_OP_IMM, OPC_OP: begin
                reg_we_o    <= rd_write;
                reg_waddr_o <= reg_waddr_i;
                reg_wdata_o <= alu_result;
              end
              OPC_BRANCH: begin
                if (branch_taken) begin
                  jump_flag_o <= 1'b1;
                  jump_addr_o <= jump_sum;
                end
              end
              OPC_JAL, OPC_JALR: begin
                reg_we_o    <= rd_write;
                reg_waddr_o <= reg_waddr_i;
                reg_wdata_o <= op_sum;
                jump_flag_o <= 1'b1;
                jump_addr_o <= (opcode == OPC_JALR) ? {jump_sum[31:1], 1'b0} : jump_sum;
              end
              OPC_SYSTEM: begin
                if (funct3 != 3'b000) begin
                  reg_we_o    <= rd_write;
                  reg_waddr_o <= reg_waddr_i;
                  reg_wdata_o <= csr_rdata_i;
                  csr_we_o    <= csr_we_i;
                  csr_waddr_o <= csr_waddr_i;
                  csr_wdata_o <= csr_next;
                end
              end
              OPC_LOAD, OPC_STORE: begin
                if (lsu_misalign) begin
                  misalign_o <= 1'b1;
                end else begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= (opcode == OPC_STORE);
                  mem_addr_o  <= lsu_word_addr;
                  mem_sel_o   <= lsu_sel;
                  mem_wdata_o <= lsu_wdata;
                  ld_funct3   <= funct3;
                  ld_offset   <= lsu_addr[1:0];
                  ld_rd       <= reg_waddr_i;
                  ld_we       <= (opcode == OPC_LOAD) & rd_write;
                  state       <= EX_MEM_WAIT;
                end
              end
              default: ;
            endcase
          end
        end
        EX_MEM_WAIT: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state     <= EX_IDLE;
            if (ld_we) begin
              reg_we_o    <= 1'b1;
              reg_waddr_o <= ld_rd;
              reg_wdata_o <= lsu_load_data;
            end
          end
        end
        default: state <= EX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed bench for ex: stimulus pushes expected writebacks, redirects,
// bus requests and misalign pulses; a negedge monitor pops and compares.
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] inst_i = '0, inst_addr_i = '0;
  logic [31:0] op1_i = '0, op2_i = '0, op1_jump_i = '0, op2_jump_i = '0;
  logic [31:0] reg1_rdata_i = '0, reg2_rdata_i = '0;
  logic        reg_we_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        csr_we_i = 1'b0;
  logic [31:0] csr_rdata_i = '0, csr_waddr_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        ready_o, jump_flag_o, mem_req_o, mem_we_o, reg_we_o, csr_we_o, misalign_o;
  logic [31:0] jump_addr_o, mem_addr_o, mem_wdata_o, reg_wdata_o, csr_waddr_o, csr_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [4:0]  reg_waddr_o;
  ex_state_t   fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] reg_exp_q[$];   // {waddr, wdata}
  logic [31:0] jump_exp_q[$];
  logic [63:0] csr_exp_q[$];   // {waddr, wdata}
  logic [68:0] mem_exp_q[$];   // {is_store, addr, wdata, sel}
  logic [0:0]  mis_exp_q[$];

  ex dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .op1_jump_i(op1_jump_i), .op2_jump_i(op2_jump_i),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .csr_we_i(csr_we_i), .csr_rdata_i(csr_rdata_i), .csr_waddr_i(csr_waddr_i),
    .ready_o(ready_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .misalign_o(misalign_o), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [68:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event value %h, nothing expected", name, act);
  endtask

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [4:0] rs1,
                                      input logic [4:0] rd);
    return {f7, 5'd0, rs1, f3, rd, opc};
  endfunction

  // Driver tasks
  task automatic send(input logic [31:0] inst, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [31:0] op1j, input logic [31:0] op2j,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
                      input logic cwe, input logic [31:0] crdata, input logic [31:0] cwaddr);
    @(negedge clk);
    inst_i = inst; op1_i = op1; op2_i = op2; op1_jump_i = op1j; op2_jump_i = op2j;
    reg1_rdata_i = r1; reg2_rdata_i = r2; reg_we_i = 1'b1; reg_waddr_i = rd;
    csr_we_i = cwe; csr_rdata_i = crdata; csr_waddr_i = cwaddr;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic alu(input logic [31:0] inst, input logic [31:0] op1, input logic [31:0] op2,
                     input logic [4:0] rd);
    send(inst, op1, op2, 0, 0, 0, 0, rd, 1'b0, 0, 0);
  endtask

  // Waits (bounded) for the request, then acks after 'delay' wait cycles.
  task automatic mem_ack(input int delay, input logic [31:0] rdata);
    int lows = 0;
    int n = 0;
    while (!mem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_seen", {68'd0, mem_req_o}, 69'd1);
    for (int k = 1; k <= delay + 1; k++) begin
      @(negedge clk);
      if (!ready_o) lows++;
      if (k == delay + 1) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = rdata;
      end
    end
    @(posedge clk);
    #1 mem_ack_i = 1'b0;
    check("ready_low_cycles", 69'(lows), 69'(delay + 1));
    @(negedge clk);
    check("mem_req_after_ack", {68'd0, mem_req_o}, 69'd0);
    check("ready_after_ack", {68'd0, ready_o}, 69'd1);
  endtask

  // Scoreboard monitor
  logic        mem_prev = 1'b0;
  logic [68:0] mem_cur = '0;

  always @(negedge clk) begin
    logic [68:0] e;
    if (reg_we_o) begin
      if (reg_exp_q.size() == 0) unexpected("reg_wb", {32'd0, reg_waddr_o, reg_wdata_o});
      else begin
        e = 69'(reg_exp_q.pop_front());
        check("reg_wb", {32'd0, reg_waddr_o, reg_wdata_o}, e);
      end
    end
    if (jump_flag_o) begin
      if (jump_exp_q.size() == 0) unexpected("jump", 69'(jump_addr_o));
      else check("jump_addr", 69'(jump_addr_o), 69'(jump_exp_q.pop_front()));
    end
    if (csr_we_o) begin
      if (csr_exp_q.size() == 0) unexpected("csr_wb", {5'd0, csr_waddr_o, csr_wdata_o});
      else check("csr_wb", {5'd0, csr_waddr_o, csr_wdata_o}, 69'(csr_exp_q.pop_front()));
    end
    if (misalign_o) begin
      if (mis_exp_q.size() == 0) unexpected("misalign", 69'd1);
      else check("misalign", 69'd1, 69'(mis_exp_q.pop_front()));
    end
    if (mem_req_o) begin
      if (!mem_prev) begin
        if (mem_exp_q.size() == 0) unexpected("mem_req", {mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o});
        else mem_cur = mem_exp_q.pop_front();
      end
      if (mem_cur[68])
        check("mem_store_req", {mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o}, mem_cur);
      else
        check("mem_load_req", {36'd0, mem_we_o, mem_addr_o}, {36'd0, mem_cur[68:36]});
    end
    mem_prev = mem_req_o;
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {68'd0, mem_req_o}, 69'd0);
    check("rst_reg_we", {68'd0, reg_we_o}, 69'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {68'd0, ready_o}, 69'd1);
    check("rst_state", {68'd0, fsm_state}, {68'd0, EX_IDLE});
    check("rst_outputs", {jump_flag_o, misalign_o, csr_we_o, jump_addr_o, reg_wdata_o},
          69'd0);

    // ALU, back to back
    reg_exp_q.push_back({5'd5, 32'h8000_0000});
    alu(enc(OPC_OP_IMM, 3'b000, 7'h00, 0, 5), 32'h7FFF_FFFF, 32'd1, 5'd5);
    reg_exp_q.push_back({5'd6, 32'hFFFF_FFFE});
    alu(enc(OPC_OP, 3'b000, 7'h20, 0, 6), 32'd5, 32'd7, 5'd6);
    reg_exp_q.push_back({5'd7, 32'hF800_0000});
    alu(enc(OPC_OP, 3'b101, 7'h20, 0, 7), 32'h8000_0000, 32'd4, 5'd7);
    reg_exp_q.push_back({5'd8, 32'h0800_0000});
    alu(enc(OPC_OP_IMM, 3'b101, 7'h00, 0, 8), 32'h8000_0000, 32'h24, 5'd8);
    reg_exp_q.push_back({5'd9, 32'd1});
    alu(enc(OPC_OP, 3'b010, 7'h00, 0, 9), 32'hFFFF_FFFF, 32'd1, 5'd9);
    reg_exp_q.push_back({5'd9, 32'd0});
    alu(enc(OPC_OP, 3'b011, 7'h00, 0, 9), 32'hFFFF_FFFF, 32'd1, 5'd9);
    alu(enc(OPC_OP_IMM, 3'b000, 7'h00, 0, 0), 32'd3, 32'd4, 5'd0);

    // BLT taken squashes the next bundle; BEQ not taken does not
    jump_exp_q.push_back(32'h120);
    send(enc(OPC_BRANCH, F3_BLT, 7'h00, 0, 0), 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20,
         0, 0, 5'd0, 1'b0, 0, 0);
    alu(enc(OPC_OP_IMM, 3'b000, 7'h00, 0, 9), 32'd1, 32'd1, 5'd9);
    send(enc(OPC_BRANCH, F3_BEQ, 7'h00, 0, 0), 32'd1, 32'd2, 32'h200, 32'h4,
         0, 0, 5'd0, 1'b0, 0, 0);
    reg_exp_q.push_back({5'd4, 32'h30});
    alu(enc(OPC_OP_IMM, 3'b000, 7'h00, 0, 4), 32'h10, 32'h20, 5'd4);

    // LH with two wait cycles, LBU with one
    mem_exp_q.push_back({1'b0, 32'h1000, 32'd0, 4'd0});
    reg_exp_q.push_back({5'd10, 32'hFFFF_8001});
    send(enc(OPC_LOAD, F3_LH, 7'h00, 0, 10), 32'h1000, 32'd2, 0, 0, 0, 0, 5'd10, 1'b0, 0, 0);
    mem_ack(2, 32'h8001_1234);
    mem_exp_q.push_back({1'b0, 32'h3000, 32'd0, 4'd0});
    reg_exp_q.push_back({5'd14, 32'h0000_0083});
    send(enc(OPC_LOAD, F3_LBU, 7'h00, 0, 14), 32'h3000, 32'd1, 0, 0, 0, 0, 5'd14, 1'b0, 0, 0);
    mem_ack(1, 32'h1122_8344);

    // Stores with ack in the first request cycle, then misaligned SW
    mem_exp_q.push_back({1'b1, 32'h2000, 32'hABAB_ABAB, 4'b1000});
    send(enc(OPC_STORE, 3'b000, 7'h00, 0, 0), 32'h2000, 32'd3, 0, 0, 0, 32'h1234_56AB,
         5'd0, 1'b0, 0, 0);
    mem_ack(0, 32'd0);
    mem_exp_q.push_back({1'b1, 32'h2000, 32'hBEEF_BEEF, 4'b1100});
    send(enc(OPC_STORE, 3'b001, 7'h00, 0, 0), 32'h2000, 32'd2, 0, 0, 0, 32'h0000_BEEF,
         5'd0, 1'b0, 0, 0);
    mem_ack(0, 32'd0);
    mis_exp_q.push_back(1'b1);
    send(enc(OPC_STORE, 3'b010, 7'h00, 0, 0), 32'h2000, 32'd2, 0, 0, 0, 32'h5555_5555,
         5'd0, 1'b0, 0, 0);
    @(negedge clk);
    check("misalign_no_req", {67'd0, mem_req_o, ready_o}, 69'd1);

    // CSR register and immediate forms
    csr_exp_q.push_back({32'h300, 32'hF0});
    reg_exp_q.push_back({5'd11, 32'hFF});
    send(enc(OPC_SYSTEM, 3'b011, 7'h00, 1, 11), 0, 0, 0, 0, 32'h0F, 0, 5'd11,
         1'b1, 32'hFF, 32'h300);
    csr_exp_q.push_back({32'h301, 32'h15});
    reg_exp_q.push_back({5'd12, 32'h10});
    send(enc(OPC_SYSTEM, 3'b110, 7'h00, 5, 12), 0, 0, 0, 0, 32'hFFFF_0000, 0, 5'd12,
         1'b1, 32'h10, 32'h301);

    // JALR clears bit 0; JAL does not
    reg_exp_q.push_back({5'd1, 32'h2004});
    jump_exp_q.push_back(32'h1004);
    send(enc(OPC_JALR, 3'b000, 7'h00, 0, 1), 32'h2000, 32'd4, 32'h1001, 32'h4,
         0, 0, 5'd1, 1'b0, 0, 0);
    @(posedge clk);
    reg_exp_q.push_back({5'd1, 32'h44});
    jump_exp_q.push_back(32'h91);
    send(enc(OPC_JAL, 3'b000, 7'h00, 0, 1), 32'h40, 32'd4, 32'h80, 32'h11,
         0, 0, 5'd1, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    check("jump_addr_hold", 69'(jump_addr_o), 69'h91);

    // Reset mid-load, then a stray ack while idle
    mem_exp_q.push_back({1'b0, 32'h4000, 32'd0, 4'd0});
    send(enc(OPC_LOAD, F3_LW, 7'h00, 0, 13), 32'h4000, 32'd0, 0, 0, 0, 0, 5'd13, 1'b0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_req", {68'd0, mem_req_o}, 69'd0);
    check("rst_async_state", {68'd0, fsm_state}, {68'd0, EX_IDLE});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {68'd0, ready_o}, 69'd1);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ack_ignored", {67'd0, ready_o, reg_we_o}, 69'd2);

    check("reg_q_drained", 69'(reg_exp_q.size()), 69'd0);
    check("jump_q_drained", 69'(jump_exp_q.size()), 69'd0);
    check("csr_q_drained", 69'(csr_exp_q.size()), 69'd0);
    check("mem_q_drained", 69'(mem_exp_q.size()), 69'd0);
    check("mis_q_drained", 69'(mis_exp_q.size()), 69'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit reached");
    $fatal(1, "timeout");
  end

endmodule
